// File: rtl/mem_access.sv
// mem_access: memory-access stage downstream of execute.
//   Registers execute results into one-cycle commit strobes (register
//   writeback, CPSR update, PC redirect). Performs load/store transactions on
//   the data-memory req/ack port, and aborts a transaction if mem_req stays
//   high for MEM_TIMEOUT edges without an ack.
// Ports:
//   clk, reset_n         clock (rising edge), async active-low reset
//   in_valid / in_ready  execute handshake; in_ready is high only in IDLE
//   result, cpsr_in, taken, rd_num, rd_val, md, is_*_op   execute outputs
//   mem_req/we/addr/wdata, mem_ack, mem_rdata             data-memory port
//   wb_en/wb_rd_num/wb_rd_val                             register writeback
//   cpsr_we/cpsr_out                                      CPSR update
//   pc_we/pc_target                                       PC redirect
//   mem_err                                               timeout abort pulse
module mem_access #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] result,
  input  logic [31:0] cpsr_in,
  input  logic        taken,
  input  logic [3:0]  rd_num,
  input  logic [31:0] rd_val,
  input  logic [31:0] md,
  input  logic        is_alu_op,
  input  logic        is_cmp_op,
  input  logic        is_jmp_op,
  input  logic        is_ld_op,
  input  logic        is_str_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [3:0]  wb_rd_num,
  output logic [31:0] wb_rd_val,
  output logic        cpsr_we,
  output logic [31:0] cpsr_out,
  output logic        pc_we,
  output logic [31:0] pc_target,
  output logic        mem_err
);

  typedef enum logic {IDLE, MEM} state_t;

  state_t     state_q, state_d;
  logic [7:0] tmo_cnt;
  logic [3:0] ld_rd;
  logic       accept;
  logic       acc_mem, acc_alu, acc_cmp, acc_jmp;
  logic       mem_done, mem_tmo;
  logic       unused_cpsr_hi;

  // Only nzcv is architecturally meaningful.
  always_comb unused_cpsr_hi = ^cpsr_in[31:4];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Decode: handshake, class priority ld > str > alu > cmp > jmp, completion.
  always_comb begin
    in_ready = (state_q == IDLE);
    accept   = in_valid && in_ready;
    acc_mem  = accept && (is_ld_op || is_str_op);
    acc_alu  = accept && !is_ld_op && !is_str_op && is_alu_op;
    acc_cmp  = accept && !is_ld_op && !is_str_op && !is_alu_op && is_cmp_op;
    acc_jmp  = accept && !is_ld_op && !is_str_op && !is_alu_op && !is_cmp_op &&
               is_jmp_op && taken;
    mem_done = (state_q == MEM) && mem_req && mem_ack;
    // Ack on the same edge the count would expire wins over the abort.
    mem_tmo  = (state_q == MEM) && mem_req && !mem_ack &&
               (tmo_cnt == 8'(MEM_TIMEOUT - 1));
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc_mem) state_d = MEM;
      MEM:     if (mem_done || mem_tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: strobes default low, data outputs hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_en     <= 1'b0;
      wb_rd_num <= '0;
      wb_rd_val <= '0;
      cpsr_we   <= 1'b0;
      cpsr_out  <= '0;
      pc_we     <= 1'b0;
      pc_target <= '0;
      mem_err   <= 1'b0;
      tmo_cnt   <= '0;
      ld_rd     <= '0;
    end else begin
      wb_en   <= 1'b0;
      cpsr_we <= 1'b0;
      pc_we   <= 1'b0;
      mem_err <= 1'b0;

      if (acc_mem) begin
        mem_req   <= 1'b1;
        mem_we    <= !is_ld_op;
        mem_addr  <= md;
        mem_wdata <= is_ld_op ? '0 : rd_val;
        ld_rd     <= rd_num;
        tmo_cnt   <= '0;
      end

      if (acc_alu) begin
        wb_en     <= 1'b1;
        wb_rd_num <= rd_num;
        wb_rd_val <= result;
      end

      if (acc_cmp) begin
        cpsr_we  <= 1'b1;
        cpsr_out <= {28'd0, cpsr_in[3:0]};
      end

      if (acc_jmp) begin
        pc_we     <= 1'b1;
        pc_target <= md;
      end

      if (mem_done) begin
        mem_req <= 1'b0;
        if (!mem_we) begin
          wb_en     <= 1'b1;
          wb_rd_num <= ld_rd;
          wb_rd_val <= mem_rdata;
        end
      end else if (mem_tmo) begin
        mem_req <= 1'b0;
        mem_err <= 1'b1;
      end else if (state_q == MEM) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_access;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] result, cpsr_in, rd_val, md;
  logic        taken;
  logic [3:0]  rd_num;
  logic        is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_en, cpsr_we, pc_we, mem_err;
  logic [3:0]  wb_rd_num;
  logic [31:0] wb_rd_val, cpsr_out, pc_target;

  always #5 clk = ~clk;

  mem_access #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .cpsr_in(cpsr_in), .taken(taken),
    .rd_num(rd_num), .rd_val(rd_val), .md(md),
    .is_alu_op(is_alu_op), .is_cmp_op(is_cmp_op), .is_jmp_op(is_jmp_op),
    .is_ld_op(is_ld_op), .is_str_op(is_str_op),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_rd_num(wb_rd_num), .wb_rd_val(wb_rd_val),
    .cpsr_we(cpsr_we), .cpsr_out(cpsr_out),
    .pc_we(pc_we), .pc_target(pc_target), .mem_err(mem_err)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Expected outputs of the current cycle (e_*) and of the next one (n_*).
  logic        e_req, e_we, e_wb, e_cw, e_pw, e_err;
  logic [31:0] e_addr, e_wdata, e_wbv, e_co, e_pt;
  logic [3:0]  e_wbn;
  logic        n_req, n_we, n_wb, n_cw, n_pw, n_err;
  logic [31:0] n_addr, n_wdata, n_wbv, n_co, n_pt;
  logic [3:0]  n_wbn;
  // Pending transaction bookkeeping.
  logic [3:0]  m_rd, n_rd;
  int          e_waits, n_waits;
  int          ack_at;      // edge (counted from mem_req rising) that carries the ack
  int          force_lat = 0;
  bit          ack_noise = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    e_req = 0; e_we = 0; e_wb = 0; e_cw = 0; e_pw = 0; e_err = 0;
    e_addr = 0; e_wdata = 0; e_wbv = 0; e_co = 0; e_pt = 0; e_wbn = 0;
    m_rd = 0; e_waits = 0;
  endtask

  // What the stage must show after the coming edge, given current inputs.
  task automatic model_next();
    n_req = e_req; n_we = e_we; n_addr = e_addr; n_wdata = e_wdata;
    n_wbn = e_wbn; n_wbv = e_wbv; n_co = e_co; n_pt = e_pt;
    n_wb = 0; n_cw = 0; n_pw = 0; n_err = 0;
    n_rd = m_rd; n_waits = e_waits;
    if (e_req) begin
      if (mem_ack) begin
        n_req = 0;
        if (!e_we) begin n_wb = 1; n_wbn = m_rd; n_wbv = mem_rdata; end
      end else if (e_waits + 1 == TMO) begin
        n_req = 0; n_err = 1;
      end else begin
        n_waits = e_waits + 1;
      end
    end else if (in_valid) begin
      if (is_ld_op || is_str_op) begin
        n_req = 1; n_we = !is_ld_op; n_addr = md;
        n_wdata = is_ld_op ? 32'd0 : rd_val;
        n_rd = rd_num; n_waits = 0;
        ack_at = (force_lat != 0) ? force_lat : int'($urandom_range(1, TMO + 2));
      end else if (is_alu_op) begin
        n_wb = 1; n_wbn = rd_num; n_wbv = result;
      end else if (is_cmp_op) begin
        n_cw = 1; n_co = {28'd0, cpsr_in[3:0]};
      end else if (is_jmp_op && taken) begin
        n_pw = 1; n_pt = md;
      end
    end
  endtask

  task automatic commit();
    e_req = n_req; e_we = n_we; e_addr = n_addr; e_wdata = n_wdata;
    e_wb = n_wb; e_wbn = n_wbn; e_wbv = n_wbv; e_cw = n_cw; e_co = n_co;
    e_pw = n_pw; e_pt = n_pt; e_err = n_err; m_rd = n_rd; e_waits = n_waits;
  endtask

  // One clock: play memory, predict, advance, land #1 after the edge.
  task automatic run_cycle();
    if (e_req) mem_ack = (e_waits + 1 == ack_at);
    else       mem_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    model_next();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic set_in(input logic v, input logic ld, input logic st, input logic alu,
                        input logic cmp, input logic jmp, input logic tk,
                        input logic [3:0] rn, input logic [31:0] res,
                        input logic [31:0] cp, input logic [31:0] rv, input logic [31:0] a);
    in_valid = v; is_ld_op = ld; is_str_op = st; is_alu_op = alu;
    is_cmp_op = cmp; is_jmp_op = jmp; taken = tk; rd_num = rn;
    result = res; cpsr_in = cp; rd_val = rv; md = a;
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  {31'd0, in_ready}, {31'd0, !e_req});
      chk("mem_req",   {31'd0, mem_req},  {31'd0, e_req});
      chk("mem_err",   {31'd0, mem_err},  {31'd0, e_err});
      chk("wb_en",     {31'd0, wb_en},    {31'd0, e_wb});
      chk("wb_rd_num", {28'd0, wb_rd_num}, {28'd0, e_wbn});
      chk("wb_rd_val", wb_rd_val, e_wbv);
      chk("cpsr_we",   {31'd0, cpsr_we},  {31'd0, e_cw});
      chk("cpsr_out",  cpsr_out, e_co);
      chk("pc_we",     {31'd0, pc_we},    {31'd0, e_pw});
      chk("pc_target", pc_target, e_pt);
      if (e_req) begin
        chk("mem_we",    {31'd0, mem_we}, {31'd0, e_we});
        chk("mem_addr",  mem_addr,  e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  initial begin
    reset_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    set_in(0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
    chk("rst_wb_rd_val", wb_rd_val, 32'd0);
    chk("rst_pc_target", pc_target, 32'd0);

    // ALU writeback
    set_in(1, 0, 0, 1, 0, 0, 0, 4'd3, 32'h42, 32'd0, 32'd0, 32'd0);
    run_cycle();
    chk("alu_wb_en",  {31'd0, wb_en}, 32'd1);
    chk("alu_wb_num", {28'd0, wb_rd_num}, 32'd3);
    chk("alu_wb_val", wb_rd_val, 32'h42);
    chk("model_alu_val", e_wbv, 32'h42);
    set_in(0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    run_cycle();
    chk("alu_wb_once", {31'd0, wb_en}, 32'd0);
    chk("alu_wb_hold", wb_rd_val, 32'h42);

    // CMP, taken JMP, untaken JMP
    set_in(1, 0, 0, 0, 1, 0, 0, 4'd0, 32'd0, 32'hFFFF_FFF6, 32'd0, 32'd0);
    run_cycle();
    chk("cmp_we",  {31'd0, cpsr_we}, 32'd1);
    chk("cmp_out", cpsr_out, 32'h6);
    set_in(1, 0, 0, 0, 0, 1, 1, 4'd0, 32'd0, 32'd0, 32'd0, 32'h100);
    run_cycle();
    chk("cmp_once", {31'd0, cpsr_we}, 32'd0);
    chk("jmp_we",   {31'd0, pc_we}, 32'd1);
    chk("jmp_tgt",  pc_target, 32'h100);
    set_in(1, 0, 0, 0, 0, 1, 0, 4'd0, 32'd0, 32'd0, 32'd0, 32'h200);
    run_cycle();
    chk("jmp_nt_we",  {31'd0, pc_we}, 32'd0);
    chk("jmp_nt_tgt", pc_target, 32'h100);

    // Load acked on the 3rd edge after mem_req rises; an ALU op waits meanwhile
    mem_rdata = 32'hDEAD_BEEF;
    force_lat = 3;
    set_in(1, 1, 0, 0, 0, 0, 0, 4'd5, 32'd0, 32'd0, 32'd0, 32'h20);
    run_cycle();
    chk("ld_req",   {31'd0, mem_req}, 32'd1);
    chk("ld_ready", {31'd0, in_ready}, 32'd0);
    chk("ld_addr",  mem_addr, 32'h20);
    chk("ld_we",    {31'd0, mem_we}, 32'd0);
    set_in(1, 0, 0, 1, 0, 0, 0, 4'd9, 32'h77, 32'd0, 32'd0, 32'd0);
    run_cycle();
    run_cycle();
    chk("ld_req3",   {31'd0, mem_req}, 32'd1);
    chk("ld_nowb",   {31'd0, wb_en}, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    run_cycle();
    chk("ld_done_req", {31'd0, mem_req}, 32'd0);
    chk("ld_wb_en",    {31'd0, wb_en}, 32'd1);
    chk("ld_wb_num",   {28'd0, wb_rd_num}, 32'd5);
    chk("ld_wb_val",   wb_rd_val, 32'hDEAD_BEEF);
    chk("ld_ready_back", {31'd0, in_ready}, 32'd1);

    // Store acked on the first edge
    force_lat = 1;
    set_in(1, 0, 1, 0, 0, 0, 0, 4'd2, 32'd0, 32'd0, 32'h1234, 32'h24);
    run_cycle();
    chk("st_req",   {31'd0, mem_req}, 32'd1);
    chk("st_we",    {31'd0, mem_we}, 32'd1);
    chk("st_wdata", mem_wdata, 32'h1234);
    set_in(0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    run_cycle();
    chk("st_req_fall", {31'd0, mem_req}, 32'd0);
    chk("st_no_wb",    {31'd0, wb_en}, 32'd0);

    // Load with no ack: timeout after TMO cycles of mem_req
    force_lat = 99;
    set_in(1, 1, 0, 0, 0, 0, 0, 4'd7, 32'd0, 32'd0, 32'd0, 32'h40);
    run_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (TMO - 1) run_cycle();
    chk("tmo_req_last", {31'd0, mem_req}, 32'd1);
    run_cycle();
    chk("tmo_req_fall", {31'd0, mem_req}, 32'd0);
    chk("tmo_err",      {31'd0, mem_err}, 32'd1);
    chk("tmo_no_wb",    {31'd0, wb_en}, 32'd0);
    chk("tmo_ready",    {31'd0, in_ready}, 32'd1);
    run_cycle();
    chk("tmo_err_once", {31'd0, mem_err}, 32'd0);

    // Ack on the edge the count would expire: success
    force_lat = TMO;
    mem_rdata = 32'hCAFE_0001;
    set_in(1, 1, 0, 0, 0, 0, 0, 4'd8, 32'd0, 32'd0, 32'd0, 32'h44);
    run_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (TMO) run_cycle();
    chk("late_ack_err", {31'd0, mem_err}, 32'd0);
    chk("late_ack_wb",  {31'd0, wb_en}, 32'd1);
    chk("late_ack_val", wb_rd_val, 32'hCAFE_0001);

    // Reset in the middle of a transaction
    force_lat = 99;
    set_in(1, 1, 0, 0, 0, 0, 0, 4'd4, 32'd0, 32'd0, 32'd0, 32'h80);
    run_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    chk("rst_mid_req",  {31'd0, mem_req}, 32'd0);
    chk("rst_mid_wbv",  wb_rd_val, 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);

    // Randomized traffic
    force_lat = 0;
    ack_noise = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      set_in(1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
             4'($urandom), $urandom, $urandom, $urandom, $urandom);
      mem_rdata = $urandom;
      run_cycle();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers execute results and performs load/store transactions on the data-memory port through a req/ack handshake.
- Produces one-cycle commit strobes for register writeback, CPSR update and PC redirect.
- Stalls execute with in_ready while a memory transaction is outstanding.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles mem_req may stay high without mem_ack before the access is aborted (legal range 1..255).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute outputs are valid this cycle
- in_ready  out  1  stage can accept; combinational, high only in IDLE
- result  in  32  ALU result
- cpsr_in  in  32  comparator output; only [3:0] nzcv is used
- taken  in  1  branch condition true
- rd_num  in  4  destination/source register number
- rd_val  in  32  store data
- md  in  32  sign-extended memory/jump address
- is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op  in  1 each  instruction class
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  32  word address
- mem_wdata  out  32  store data
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  32  load data, valid with mem_ack
- wb_en  out  1  one-cycle register write strobe
- wb_rd_num  out  4  register written
- wb_rd_val  out  32  value written
- cpsr_we  out  1  one-cycle CPSR write strobe
- cpsr_out  out  32  {28'd0, nzcv}
- pc_we  out  1  one-cycle PC redirect strobe
- pc_target  out  32  redirect target
- mem_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, wb_*, cpsr_*, pc_*, mem_err); timeout counter 0.
  - Reset asserted mid-transaction drops mem_req immediately; the access produces no writeback.
- States: IDLE, MEM.
- Accept: an instruction is accepted on a rising edge where in_valid && in_ready.
- Class priority when several flags are set: ld > str > alu > cmp > jmp. Lower-priority flags are ignored.
- Strobes: wb_en, cpsr_we, pc_we and mem_err are high for exactly one cycle and default to 0 every other cycle.
- Data outputs (wb_rd_num, wb_rd_val, cpsr_out, pc_target) hold their last value when their strobe is low.
- ALU accepted at edge N: during cycle N+1, wb_en=1, wb_rd_num=rd_num, wb_rd_val=result.
- CMP accepted at edge N: cpsr_we=1 and cpsr_out={28'd0, cpsr_in[3:0]} in cycle N+1.
- JMP accepted at edge N:
  - If taken=1: pc_we=1 and pc_target=md in cycle N+1.
  - If taken=0: no strobe.
- LD/ST accepted at edge N:
  - Transition to MEM. From cycle N+1: mem_req=1, mem_addr=md, mem_we=is_str_op, mem_wdata=rd_val (0 for loads).
  - Captured rd_num is held internally.
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1.
- MEM state:
  - in_ready=0.
  - Each edge with mem_req && mem_ack completes the access: mem_req falls, state returns to IDLE, and in_ready=1 in the following cycle.
  - A load completion at edge M drives wb_en=1, wb_rd_num=captured rd_num, wb_rd_val=mem_rdata (sampled at M) in cycle M+1.
  - A store completion produces no strobe.
- mem_ack is ignored while mem_req=0.
- Timeout:
  - The counter starts at 0 when mem_req rises and increments on each edge without ack.
  - When it reaches MEM_TIMEOUT, mem_req falls, mem_err pulses for one cycle, there is no writeback, and the state returns to IDLE.
  - mem_ack arriving on the same edge the counter reaches MEM_TIMEOUT counts as success.
- Back-to-back: in IDLE the stage accepts one instruction per cycle.
- Addresses pass through unchanged; alignment is the memory's concern.

Test Plan:
- ALU: result=0x0000_0042, rd_num=3, accepted edge 1 -> wb_en=1, wb_rd_num=3, wb_rd_val=0x42 in cycle 2 only.
- CMP with cpsr_in=0xFFFF_FFF6, then taken JMP md=0x100, then untaken JMP -> cpsr_out=0x6 with cpsr_we 1 cycle; pc_we 1 cycle with pc_target=0x100; no strobe for the untaken jump.
- LD md=0x20, rd_num=5, mem_ack after 3 cycles with rdata=0xDEADBEEF -> mem_req high 3 cycles, in_ready low throughout, wb_rd_val=0xDEADBEEF to r5 one cycle after ack.
- ST md=0x24, rd_val=0x1234, ack same cycle mem_req rises -> mem_we=1, mem_wdata=0x1234, mem_req high exactly 1 cycle, no wb_en.
- LD with no ack, MEM_TIMEOUT=4 -> mem_req high 4 cycles, mem_err pulse, no wb_en, in_ready returns to 1; repeat with ack on the 4th edge -> success, no mem_err.
- reset_n pulled low while mem_req=1 -> mem_req=0 immediately; after release, state=IDLE and all outputs 0.
